// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler feeding a single UART transmitter (core stdout, status messages).
// Latency: byte pushed into idle, empty scheduler appears as a tx_en_o pulse two edges later.
// Backpressure: per-requester ready drops when its FIFO is full; bytes offered while full are dropped and flagged.
module uart_tx_sched #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       core_valid_i,
    input  logic [7:0] core_data_i,
    output logic       core_ready_o,
    input  logic       stat_valid_i,
    input  logic [7:0] stat_data_i,
    output logic       stat_ready_o,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    output logic       drained_o,
    output logic [1:0] overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] wptr [2];
    logic [PW-1:0] rptr [2];
    logic [7:0]    mem  [2][FIFO_DEPTH];
    logic [7:0]    in_dat [2];
    logic [1:0]    in_vld;
    logic [1:0]    not_empty;
    logic [1:0]    full;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          last_grant;
    logic          sel;
    logic [7:0]    tx_data;
    logic [1:0]    overflow;

    // FIFO status from registered pointers, push qualification and round-robin pick
    always_comb begin
        in_vld    = {stat_valid_i, core_valid_i};
        in_dat[0] = core_data_i;
        in_dat[1] = stat_data_i;
        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (wptr[i] != rptr[i]);
            full[i]      = (wptr[i][AW] != rptr[i][AW]) &&
                           (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
            push[i]      = in_vld[i] & ~full[i];
        end
        // both waiting: alternate; otherwise take whichever one has data
        sel = (&not_empty) ? ~last_grant : not_empty[1];
        pop = 2'b00;
        if ((state == IDLE) && (|not_empty)) begin
            pop[sel] = 1'b1;
        end
    end

    // FIFO pointers and sticky drop flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            overflow <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + PW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
                if (in_vld[i] && full[i]) overflow[i] <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wptr[i][AW-1:0]] <= in_dat[i];
        end
    end

    // Issue FSM: pop and latch grant in IDLE, one-cycle start, then hold until the transmitter finishes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tx_data    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|not_empty) begin
                        state      <= START;
                        last_grant <= sel;
                        tx_data    <= mem[sel][rptr[sel][AW-1:0]];
                    end
                end
                START:     state <= WAIT_DONE;
                WAIT_DONE: if (tx_done_i) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign core_ready_o = ~full[0];
    assign stat_ready_o = ~full[1];
    assign tx_en_o      = (state == START);
    assign tx_data_o    = tx_data;
    assign drained_o    = (state == IDLE) && !(|not_empty);
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a random push run.
// A behavioural transmitter answers tx_en_o with tx_done_i after a random delay.
// Expected bytes come from per-requester queues filled as the bench pushes.
module tb_uart_tx_sched;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       core_valid;
    logic [7:0] core_data;
    logic       core_ready_o;
    logic       stat_valid;
    logic [7:0] stat_data;
    logic       stat_ready_o;
    logic       tx_en_o;
    logic [7:0] tx_data_o;
    logic       tx_done;
    logic       drained_o;
    logic [1:0] overflow_o;

    uart_tx_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .core_valid_i (core_valid),
        .core_data_i  (core_data),
        .core_ready_o (core_ready_o),
        .stat_valid_i (stat_valid),
        .stat_data_i  (stat_data),
        .stat_ready_o (stat_ready_o),
        .tx_en_o      (tx_en_o),
        .tx_data_o    (tx_data_o),
        .tx_done_i    (tx_done),
        .drained_o    (drained_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] txq [$];
    logic [7:0] qc  [$];
    logic [7:0] qs  [$];
    bit         busy = 0;
    int         cnt  = 0;
    logic [7:0] held = 8'h00;
    bit         auto_done  = 1;
    bit         extra_done = 0;
    int         total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: advance to the falling edge, observe the transmitter side, drive tx_done
    task automatic tick();
        @(negedge clk);
        tx_done = extra_done;
        if (!rst_ni) begin
            busy = 0;
        end else if (tx_en_o === 1'b1) begin
            check("tx_en_while_busy", 32'(busy), 32'd0);
            txq.push_back(tx_data_o);
            held = tx_data_o;
            busy = 1;
            cnt  = 1 + int'($urandom_range(0, 3));
        end else if (busy) begin
            check("tx_data_stable", 32'(tx_data_o), 32'(held));
            if (auto_done) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    busy    = 0;
                end
            end
        end
    endtask

    task automatic wait_drained(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (drained_o === 1'b1 && !busy) break;
            tick();
        end
        check("drain_timeout", 32'(drained_o === 1'b1 && !busy), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_tx_en", 32'(tx_en_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_drained", 32'(drained_o), 32'd1);
        check("rst_core_ready", 32'(core_ready_o), 32'd1);
        check("rst_stat_ready", 32'(stat_ready_o), 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0; core_valid = 0; core_data = 0; stat_valid = 0; stat_data = 0; tx_done = 0;
        #1;
        check_reset_vals();
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // preload both requesters, requester 0 wins first after reset, then alternate
        txq.delete();
        core_valid = 1; core_data = "A"; stat_valid = 1; stat_data = "x";
        tick();
        core_data = "B"; stat_data = "y";
        tick();
        core_valid = 0; stat_valid = 0;
        wait_drained(200);
        check("rr_count", 32'(txq.size()), 32'd4);
        if (txq.size() == 4) begin
            check("rr_0", 32'(txq[0]), 32'h41);
            check("rr_1", 32'(txq[1]), 32'h78);
            check("rr_2", 32'(txq[2]), 32'h42);
            check("rr_3", 32'(txq[3]), 32'h79);
        end

        // single byte: exact start latency and one pulse
        txq.delete();
        core_valid = 1; core_data = 8'h41;
        tick();
        core_valid = 0;
        check("lat_no_early_en", 32'(tx_en_o), 32'd0);
        check("lat_not_drained", 32'(drained_o), 32'd0);
        tick();
        check("lat_tx_en", 32'(tx_en_o), 32'd1);
        check("lat_tx_data", 32'(tx_data_o), 32'h41);
        wait_drained(50);
        check("single_pulse_count", 32'(txq.size()), 32'd1);

        // tx_done while idle must be ignored
        txq.delete();
        extra_done = 1;
        tick();
        extra_done = 0;
        for (int i = 0; i < 4; i++) tick();
        check("idle_done_no_tx", 32'(txq.size()), 32'd0);
        check("idle_done_drained", 32'(drained_o), 32'd1);

        // fill: one byte in flight, DEPTH buffered, next one dropped
        txq.delete();
        auto_done = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            check("fill_ready", 32'(core_ready_o), 32'd1);
            core_valid = 1; core_data = 8'(i);
            tick();
        end
        core_valid = 0;
        check("full_core_ready", 32'(core_ready_o), 32'd0);
        check("full_inflight", 32'(txq.size()), 32'd1);
        core_valid = 1; core_data = 8'h99;
        tick();
        core_valid = 0;
        tick();
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_core_ready", 32'(core_ready_o), 32'd0);
        check("ovf_stat_ready", 32'(stat_ready_o), 32'd1);
        auto_done = 1;
        wait_drained(500);
        check("fill_tx_count", 32'(txq.size()), 32'(DEPTH + 1));
        for (int i = 0; i < txq.size(); i++) check("fill_order", 32'(txq[i]), 32'(i));
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // reset during WAIT_DONE with three bytes queued
        txq.delete();
        auto_done = 0;
        for (int i = 0; i < 4; i++) begin
            core_valid = 1; core_data = 8'hC0 + 8'(i);
            tick();
        end
        core_valid = 0;
        tick(); tick();
        check("pre_rst_busy", 32'(drained_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check_reset_vals();
        tick();
        rst_ni = 1'b1;
        txq.delete();
        auto_done = 1;
        for (int i = 0; i < 20; i++) tick();
        check("post_rst_no_tx", 32'(txq.size()), 32'd0);
        check("post_rst_drained", 32'(drained_o), 32'd1);

        // random pushes from both requesters, tagged by bit 7 to recover the source
        txq.delete();
        for (int cyc = 0; cyc < 30000 && total < 1000; cyc++) begin
            core_valid = 0; stat_valid = 0;
            if ($urandom_range(0, 1) == 1 && core_ready_o === 1'b1) begin
                core_data  = {1'b0, 7'($urandom)};
                core_valid = 1;
                qc.push_back(core_data);
                total++;
            end
            if (total < 1000 && $urandom_range(0, 1) == 1 && stat_ready_o === 1'b1) begin
                stat_data  = {1'b1, 7'($urandom)};
                stat_valid = 1;
                qs.push_back(stat_data);
                total++;
            end
            tick();
        end
        core_valid = 0; stat_valid = 0;
        wait_drained(20000);
        check("rand_push_count", 32'(total), 32'd1000);
        check("rand_tx_count", 32'(txq.size()), 32'd1000);
        foreach (txq[i]) begin
            if (txq[i][7]) begin
                check("rand_stat_avail", 32'(qs.size() != 0), 32'd1);
                if (qs.size() != 0) check("rand_stat_order", 32'(txq[i]), 32'(qs.pop_front()));
            end else begin
                check("rand_core_avail", 32'(qc.size() != 0), 32'd1);
                if (qc.size() != 0) check("rand_core_order", 32'(txq[i]), 32'(qc.pop_front()));
            end
        end
        check("rand_core_left", 32'(qc.size()), 32'd0);
        check("rand_stat_left", 32'(qs.size()), 32'd0);
        check("rand_overflow", 32'(overflow_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 8: entries per requester FIFO; power of two, 2..64.
- REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port core_valid_i, input, 1 bit: core stdout byte write strobe (requester 0).
- REQ-005 SHALL have port core_data_i, input, 8 bits: core stdout byte.
- REQ-006 SHALL have port core_ready_o, output, 1 bit: requester-0 FIFO not full.
- REQ-007 SHALL have port stat_valid_i, input, 1 bit: status/exit message byte strobe (requester 1).
- REQ-008 SHALL have port stat_data_i, input, 8 bits: status message byte.
- REQ-009 SHALL have port stat_ready_o, output, 1 bit: requester-1 FIFO not full.
- REQ-010 SHALL have port tx_en_o, output, 1 bit: one-cycle start pulse to the UART transmitter.
- REQ-011 SHALL have port tx_data_o, output, 8 bits: byte to transmit; held stable from the tx_en_o pulse until tx_done_i.
- REQ-012 SHALL have port tx_done_i, input, 1 bit: one-cycle pulse from the transmitter at end of stop bit.
- REQ-013 SHALL have port drained_o, output, 1 bit: both FIFOs empty and FSM in IDLE.
- REQ-014 SHALL have port overflow_o, output, 2 bits: sticky per-requester drop flags (bit 0 core, bit 1 stat).

Function
- REQ-015 SHALL push a byte into requester n's FIFO when valid_n is high and ready_n is high.
- REQ-016 SHALL drop a byte offered while ready_n is low and set overflow_o[n]; overflow_o SHALL clear only on reset.
- REQ-017 SHALL derive ready_n from registered FIFO occupancy; a pop in the same cycle SHALL NOT make a full FIFO accept a push.
- REQ-018 SHALL implement the FSM states IDLE, START and WAIT_DONE.
- REQ-019 IDLE -> START SHALL occur when at least one FIFO is non-empty; the grant is latched and the head byte popped into tx_data_o on this transition.
- REQ-020 SHALL arbitrate round-robin: if both FIFOs are non-empty, grant the requester not granted last; if only one is non-empty, grant it.
- REQ-021 START SHALL assert tx_en_o for exactly one cycle, then go to WAIT_DONE.
- REQ-022 WAIT_DONE -> IDLE SHALL occur on tx_done_i; tx_done_i SHALL be ignored in IDLE and START.
- REQ-023 Latency: a byte pushed into empty FIFOs with the FSM in IDLE at edge N SHALL produce tx_en_o high in the cycle after edge N+1.
- REQ-024 SHALL transmit at most one byte per tx_done_i; there is no back-to-back issue without returning to IDLE.
- REQ-025 Bytes from one requester SHALL be transmitted in push order.
- REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full when the MSBs differ and the LSBs are equal.
- REQ-027 drained_o SHALL be combinational from registered state only.

Reset
- REQ-028 While rst_ni is low, the block SHALL hold: FSM IDLE, FIFOs empty, last grant = requester 1 (so requester 0 wins first), tx_en_o=0, tx_data_o=0, overflow_o=0, drained_o=1, core_ready_o=1, stat_ready_o=1.
- REQ-029 Reset asserted mid-transmission SHALL discard all buffered bytes and the in-flight grant, with no tx_en_o afterwards until a new push.

Verification
- REQ-030 Push core byte 0x41 in IDLE -> tx_en_o pulses once with tx_data_o=0x41; drained_o=1 after tx_done_i.
- REQ-031 Preload core "AB" and stat "xy", then release -> transmit order A, x, B, y.
- REQ-032 Push 9 core bytes without tx_done_i (FIFO_DEPTH=8) -> the first byte is in flight and 8 are buffered; 10th push dropped, overflow_o=2'b01, core_ready_o=0.
- REQ-033 Pulse tx_done_i while IDLE -> no state change, no tx_en_o.
- REQ-034 Assert rst_ni low during WAIT_DONE with 3 bytes queued -> all outputs at reset values; no tx_en_o after release.
- REQ-035 Drive 1000 random pushes from both requesters -> per-requester order preserved and byte count matches; wrap-around exercised.
